// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with boot/fetch/hold control and exception/eret redirection.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] jidx,
  input  logic [31:0] rs_val,
  input  logic [31:0] epc,
  input  logic        eret,
  input  logic        exc_req,
  input  logic        stall,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        inst_valid,
  output logic        addr_err
);
  localparam logic [1:0] BOOT = 2'd0, FETCH = 2'd1, HOLD = 2'd2;
  logic [1:0]  state, state_nx;
  logic        armed;
  logic        load;
  logic [31:0] target;
  assign pc_plus4   = pc + 32'd4;
  assign imem_req   = state == FETCH;
  assign inst_valid = state == FETCH && imem_ack && !exc_req;
  always_comb begin
    target = exc_req ? EXC_VEC :
             eret ? epc :
             pc_sel == 2'd0 ? pc_plus4 :
             pc_sel == 2'd1 ? br_target :
             pc_sel == 2'd2 ? {pc_plus4[31:28], jidx, 2'b00} : rs_val;
    load = (state == FETCH && (exc_req || (imem_ack && !stall))) ||
           (state == HOLD && (exc_req || !stall));
    state_nx = state == BOOT ? (armed ? FETCH : BOOT) :
               state == FETCH ? (!exc_req && imem_ack && stall ? HOLD : FETCH) :
               state == HOLD ? (load ? FETCH : HOLD) : BOOT;
  end
  // armed delays the first FETCH by one full cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_VEC;
      state    <= BOOT;
      armed    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      armed    <= 1'b1;
      state    <= state_nx;
      addr_err <= load && |target[1:0];
      if (load) pc <= {target[31:2], 2'b00};
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: random and directed checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0040_0000, EV = 32'h0040_0004;
  logic        clk = 0, rst = 0;
  logic [1:0]  pc_sel;
  logic [31:0] br_target, rs_val, epc;
  logic [25:0] jidx;
  logic        eret, exc_req, stall, imem_ack;
  logic [31:0] pc, pc_plus4;
  logic        imem_req, inst_valid, addr_err;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] m_pc;
  int          m_boot;
  bit          m_hold, m_aerr;

  pc_sequencer #(.RESET_VEC(RV), .EXC_VEC(EV)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .br_target(br_target), .jidx(jidx),
    .rs_val(rs_val), .epc(epc), .eret(eret), .exc_req(exc_req), .stall(stall),
    .imem_ack(imem_ack), .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req),
    .inst_valid(inst_valid), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target();
    if (exc_req) return EV;
    if (eret) return epc;
    case (pc_sel)
      2'd0: return m_pc + 32'd4;
      2'd1: return br_target;
      2'd2: return ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jidx) * 4);
      default: return rs_val;
    endcase
  endfunction

  task automatic idle(input logic ack);
    pc_sel = 0; br_target = 0; jidx = 0; rs_val = 0; epc = 0;
    eret = 0; exc_req = 0; stall = 0; imem_ack = ack;
  endtask

  task automatic tick();
    logic [31:0] t;
    bit fetching, take;
    #1;
    fetching = m_boot == 0 && !m_hold;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_req", 32'(imem_req), 32'(fetching));
    check("inst_valid", 32'(inst_valid), 32'(fetching && imem_ack && !exc_req));
    check("addr_err", 32'(addr_err), 32'(m_aerr));
    if (m_boot > 0) begin
      m_boot--;
      m_aerr = 0;
    end else begin
      t = ref_target();
      take = exc_req || (m_hold ? !stall : (imem_ack && !stall));
      if (take) begin
        m_aerr = (t % 4) != 0;
        m_pc = t - (t % 4);
        m_hold = 0;
      end else begin
        m_aerr = 0;
        if (!m_hold && imem_ack && stall) m_hold = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check("rst_pc", pc, RV);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_addr_err", 32'(addr_err), 0);
    m_pc = RV; m_hold = 0; m_aerr = 0; m_boot = 2;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle(1);
    @(negedge clk);
    do_reset();
    tick(); tick();
    check("boot_done_req", 32'(imem_req), 1);
    tick(); tick();
    check("seq_pc", pc, 32'h0040_0008);
    stall = 1; tick();
    imem_ack = 0; tick(); tick();
    check("hold_pc", pc, 32'h0040_0008);
    check("hold_req", 32'(imem_req), 0);
    stall = 0; tick();
    check("after_stall", pc, 32'h0040_000C);
    idle(1); pc_sel = 1; br_target = 32'h0040_0010; tick();
    pc_sel = 2; jidx = 26'h0100010; tick();
    check("jump", pc, 32'h0040_0040);
    pc_sel = 3; rs_val = 32'h0040_1002; tick();
    check("jr_pc", pc, 32'h0040_1000);
    check("jr_aerr", 32'(addr_err), 1);
    idle(0); tick();
    exc_req = 1; eret = 1; pc_sel = 1; stall = 1; br_target = 32'h1234_5678; tick();
    check("exc_pri", pc, 32'h0040_0004);
    idle(1); eret = 1; epc = 32'h0040_0100; tick();
    check("eret", pc, 32'h0040_0100);
    idle(1); pc_sel = 3; rs_val = 32'hFFFF_FFFC; tick();
    idle(1); tick();
    check("wrap_pc", pc, 32'h0000_0000);
    check("wrap_aerr", 32'(addr_err), 0);
    idle(1); #2;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pc_sel = 2'($urandom_range(0, 3));
      br_target = $urandom; rs_val = $urandom; epc = $urandom;
      jidx = 26'($urandom);
      if ($urandom % 2 != 0) begin
        br_target[1:0] = 0; rs_val[1:0] = 0; epc[1:0] = 0;
      end
      exc_req = $urandom % 12 == 0;
      eret = $urandom % 8 == 0;
      stall = $urandom % 4 == 0;
      imem_ack = $urandom % 4 != 0;
      if ($urandom % 150 == 0) do_reset();
      else tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
